// File: rtl/up_counter_pkg.sv
// Shared counter types and elaboration-time parameter checks.
// Reusable by any counter that needs WIDTH/MAX/RESET validation.
package up_counter_pkg;

  localparam int DEF_WIDTH = 4;

  typedef logic [DEF_WIDTH-1:0] count_t;

  function automatic bit width_ok(int w);
    return (w >= 1) && (w <= 32);
  endfunction

  function automatic bit max_ok(
    int w,
    longint unsigned m
  );
    return (m >= 64'd1) && (m <= ((64'd1 << w) - 64'd1));
  endfunction

  function automatic bit reset_ok(
    longint unsigned rv,
    longint unsigned m
  );
    return rv <= m;
  endfunction

endpackage

// File: rtl/up_counter.sv
// Free-running wrapping up-counter with asynchronous active-high reset.
// Counts RESET_VALUE..MAX_COUNT, then 0..MAX_COUNT forever.
module up_counter
  import up_counter_pkg::*;
#(
  parameter int              WIDTH       = DEF_WIDTH,
  parameter longint unsigned MAX_COUNT   = (64'd1 << WIDTH) - 64'd1,
  parameter longint unsigned RESET_VALUE = 64'd0
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] counter
);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $fatal(1, "up_counter: WIDTH out of range 1..32");
  end
  if (!max_ok(WIDTH, MAX_COUNT)) begin : g_bad_max
    $fatal(1, "up_counter: MAX_COUNT out of range");
  end
  if (!reset_ok(RESET_VALUE, MAX_COUNT)) begin : g_bad_rst
    $fatal(1, "up_counter: RESET_VALUE exceeds MAX_COUNT");
  end

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] RST_W = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH:0]   sum;

  // sum > MAX covers both the terminal wrap and any out-of-range state
  always_comb begin
    sum     = {1'b0, count_q} + (WIDTH+1)'(1);
    count_d = sum[WIDTH-1:0];
    if (sum > {1'b0, MAX_W}) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= RST_W;
    end else begin
      count_q <= count_d;
    end
  end

  assign counter = count_q;

endmodule

// File: tb/tb_up_counter.sv
// Self-checking bench for up_counter: vector table, corner sequences,
// and randomized resets against a modular-arithmetic reference model.
module tb_up_counter;

  logic       clk;
  logic       r0;
  logic       r1;
  logic [3:0] c0;
  logic [3:0] c1;
  logic [0:0] c2;

  int checks;
  int errors;

  up_counter u_def (
    .clk     (clk),
    .reset   (r0),
    .counter (c0)
  );

  up_counter #(
    .WIDTH       (4),
    .MAX_COUNT   (9),
    .RESET_VALUE (3)
  ) u_mod (
    .clk     (clk),
    .reset   (r1),
    .counter (c1)
  );

  up_counter #(
    .WIDTH (1)
  ) u_w1 (
    .clk     (clk),
    .reset   (r1),
    .counter (c2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic rst;
    int   exp;
  } vec_t;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    vec_t vec[19];
    int   m0;
    int   m1;
    int   m2;

    checks = 0;
    errors = 0;
    r0 = 1'b1;
    r1 = 1'b1;

    vec = '{
      '{1'b1, 0},  '{1'b1, 0},  '{1'b0, 1},  '{1'b0, 2},
      '{1'b0, 3},  '{1'b0, 4},  '{1'b0, 5},  '{1'b0, 6},
      '{1'b0, 7},  '{1'b0, 8},  '{1'b0, 9},  '{1'b0, 10},
      '{1'b0, 11}, '{1'b0, 12}, '{1'b0, 13}, '{1'b0, 14},
      '{1'b0, 15}, '{1'b0, 0},  '{1'b0, 1}
    };

    #1;
    chk("reset_initial", int'(c0), 0);

    // Edges at 5,15 under reset; release at 20; wrap at 175
    for (int i = 0; i < 19; i++) begin
      if (i > 0) @(negedge clk);
      r0 = vec[i].rst;
      @(posedge clk);
      #1;
      chk($sformatf("table[%0d]", i), int'(c0), vec[i].exp);
    end

    m0 = 1;
    while (m0 != 8) begin
      @(posedge clk);
      #1;
      m0 = (m0 + 1) % 16;
      chk("count_to_8", int'(c0), m0);
    end

    // Asynchronous assertion between edges
    #2;
    r0 = 1'b1;
    #1;
    chk("async_reset", int'(c0), 0);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("reset_held", int'(c0), 0);
    end
    @(negedge clk);
    r0 = 1'b0;
    @(posedge clk);
    #1;
    chk("after_midreset", int'(c0), 1);

    // Release exactly at a rising edge: that edge must not count
    @(negedge clk);
    r0 = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_again", int'(c0), 0);
    @(posedge clk);
    r0 <= 1'b0;
    #1;
    chk("coincident_release", int'(c0), 0);
    @(posedge clk);
    #1;
    chk("first_after_coinc", int'(c0), 1);
    @(posedge clk);
    #1;
    chk("second_after_coinc", int'(c0), 2);

    // Non-default parameters with random resets
    #1;
    chk("mod_reset_value", int'(c1), 3);
    chk("w1_reset_value", int'(c2), 0);
    m1 = 3;
    m2 = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      r1 = (i > 2) && ($urandom_range(0, 7) == 0);
      #1;
      if (r1) begin
        m1 = 3;
        m2 = 0;
        chk("mod_async", int'(c1), m1);
        chk("w1_async", int'(c2), m2);
      end
      @(posedge clk);
      #1;
      if (!r1) begin
        m1 = (m1 + 1) % 10;
        m2 = (m2 + 1) % 2;
      end
      chk("mod_count", int'(c1), m1);
      chk("w1_count", int'(c2), m2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/up_counter.md
Name: up_counter

Overview:
- Free-running binary up-counter.
- Clears on asynchronous reset, then increments once per rising clock edge and wraps back to zero after its terminal count.
- Used as a basic timebase/sequence source. Its registered count output feeds downstream logic directly.
- No enable or load; it always counts while out of reset.

Parameters:
- WIDTH, 4, bit width of the count output; legal range 1..32.
- MAX_COUNT, 2**WIDTH-1, terminal count; the value after MAX_COUNT is 0; legal range 1..2**WIDTH-1.
- RESET_VALUE, 0, value loaded by reset; legal range 0..MAX_COUNT.

Ports:
- clk  input  1  system clock; all state changes on its rising edge except reset.
- reset  input  1  asynchronous, active-high reset.
- counter  output  WIDTH  current count; registered, no combinational path from any input.

Behaviour:
- Single clock, clk. Reset is asynchronous and active-high on reset.
- While reset=1: counter = RESET_VALUE (0 by default), immediately on assertion, independent of clk. Clock edges during reset have no effect.
- Reset deassertion: counter holds RESET_VALUE until the first rising clk edge with reset=0. At that edge counter becomes RESET_VALUE+1, or 0 if RESET_VALUE==MAX_COUNT.
- Each rising clk edge with reset=0:
  - if counter == MAX_COUNT, next = 0;
  - else next = counter + 1.
- Latency: one increment per cycle, visible right after the edge. No pipeline stages.
- Defaults: sequence is 0,1,2,…,15,0,1,… with period 16 cycles.
- Arithmetic: the addition is done at WIDTH+1 bits and truncated. No overflow flag.
- Defensive rule: if counter > MAX_COUNT (unreachable in legal operation), next = 0.
- Reset mid-count: asserting reset at any point forces RESET_VALUE at once, aborting the current count. Counting restarts from RESET_VALUE after release.
- Reset and clk edge coinciding: reset wins; counter = RESET_VALUE.
- Illegal parameter combinations (MAX_COUNT > 2**WIDTH-1, RESET_VALUE > MAX_COUNT, WIDTH outside 1..32) are rejected at elaboration with a fatal error.
- No X propagation: after the first reset, counter is always a known value.

Decomposition:
- Shared package: default WIDTH constant (4) and a count-vector typedef sized by WIDTH. Elaboration-time parameter-check helpers also live there, so other counters can reuse them.
- No sub-module: a single register plus next-state logic.
- Optional: a purely combinational next-count function in the package, reused by the bench reference model.

Test Plan:
- Defaults, 10 ns clk (first rising edge at 5 ns), reset=1 for 0–20 ns -> counter=0 throughout, including at the edges at 5 and 15 ns.
- Release reset at 20 ns -> counter=1 after 25 ns, 2 after 35 ns, 3 after 45 ns.
- Run 16 edges after release -> counter=15 after the edge at 165 ns, wraps to 0 after 175 ns, 1 after 185 ns.
- Assert reset asynchronously mid-count (e.g. 102 ns, counter=8) -> counter=0 within the same time step, no clk edge needed. Deassert at 118 ns -> counter=1 after the 125 ns edge.
- Parameters WIDTH=4, MAX_COUNT=9, RESET_VALUE=3 -> after reset 3, then 4…9, 0, 1…; verified against the package reference model for 40 cycles.
- Reset held across several edges, then released exactly coincident with a clk edge -> no increment on that edge; first increment on the following edge.
